// File: rtl/xdble_result_reader_pkg.sv
// Shared definitions for the xDBLe result unloader: CLOG2 helper macro,
// source-memory select encoding and FSM state encoding.
`ifndef CLOG2
`define CLOG2(x) (((x) <= 1) ? 1 : $clog2(x))
`endif

package xdble_result_reader_pkg;

    localparam logic [1:0] SEL_T6_0 = 2'd0;
    localparam logic [1:0] SEL_T6_1 = 2'd1;
    localparam logic [1:0] SEL_T7_0 = 2'd2;
    localparam logic [1:0] SEL_T7_1 = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/xdble_result_reader_stream_skid2.sv
// Two-entry FIFO holding captured result words ({last, sel, data}) until the
// downstream consumer accepts them. A push and a pop in the same cycle is legal when full.
module stream_skid2 #(
    parameter int W = 35
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty,
    output logic [1:0]   count
);

    logic [W-1:0] mem_q [2];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   count_q;
    logic         push_ok;
    logic         pop_ok;

    assign empty   = (count_q == 2'd0);
    assign full    = (count_q == 2'd2);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign pop_ok  = pop & ~empty;
    // When full, the slot being popped is the one overwritten by the push.
    assign push_ok = push & (~full | pop_ok);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= din;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_ok) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + 2'(push_ok) - 2'(pop_ok);
        end
    end

endmodule

// File: rtl/xdble_result_reader.sv
// Walks the four xDBLe result memories and streams every word on valid/ready.
// Optional XOR checksum of the popped words when XDBLE_RESULT_READER_CHECKSUM_EN is defined.
module xdble_result_reader
    import xdble_result_reader_pkg::*;
#(
    parameter int RADIX      = 32,
    parameter int WIDTH_REAL = 14,
    parameter int AW         = `CLOG2(WIDTH_REAL)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [1:0]       dbg_state,
    output logic             out_mem_t6_0_rd_en,
    output logic             out_mem_t6_1_rd_en,
    output logic             out_mem_t7_0_rd_en,
    output logic             out_mem_t7_1_rd_en,
    output logic [AW-1:0]    out_mem_t6_0_rd_addr,
    output logic [AW-1:0]    out_mem_t6_1_rd_addr,
    output logic [AW-1:0]    out_mem_t7_0_rd_addr,
    output logic [AW-1:0]    out_mem_t7_1_rd_addr,
    input  logic [RADIX-1:0] mem_t6_0_dout,
    input  logic [RADIX-1:0] mem_t6_1_dout,
    input  logic [RADIX-1:0] mem_t7_0_dout,
    input  logic [RADIX-1:0] mem_t7_1_dout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [RADIX-1:0] out_data,
    output logic [1:0]       out_sel,
    output logic             out_last
`ifdef XDBLE_RESULT_READER_CHECKSUM_EN
    ,
    output logic [RADIX-1:0] checksum
`endif
);

    localparam int          FW        = RADIX + 3;
    localparam logic [AW-1:0] LAST_ADDR = AW'(WIDTH_REAL - 1);

    state_e          state_q, state_d;
    logic [1:0]      sel_q, sel_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            infl_q;
    logic [1:0]      infl_sel_q;
    logic            infl_last_q;

    logic            issue;
    logic            last_issue;
    logic            pop;
    logic [1:0]      occ_after_pop;
    logic [RADIX-1:0] cap_data;
    logic [FW-1:0]   fifo_din;
    logic [FW-1:0]   fifo_dout;
    logic            fifo_full;
    logic            fifo_empty;
    logic [1:0]      fifo_count;

    assign dbg_state = state_q;

    assign pop           = ~fifo_empty & out_ready;
    assign occ_after_pop = fifo_count - 2'(pop);
    // A slot freed by this cycle's pop may be reused by the read issued now.
    assign issue      = (state_q == ST_RUN) && !(fifo_full && !pop)
                        && ((occ_after_pop + 2'(infl_q)) < 2'd2);
    assign last_issue = issue && (sel_q == SEL_T7_1) && (addr_q == LAST_ADDR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            sel_q       <= SEL_T6_0;
            addr_q      <= '0;
            infl_q      <= 1'b0;
            infl_sel_q  <= SEL_T6_0;
            infl_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            addr_q      <= addr_d;
            infl_q      <= issue;
            infl_sel_q  <= sel_q;
            infl_last_q <= last_issue;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        addr_d  = addr_q;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    sel_d   = SEL_T6_0;
                    addr_d  = '0;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (issue) begin
                    if (addr_q == LAST_ADDR) begin
                        addr_d = '0;
                        sel_d  = sel_q + 2'd1;
                    end else begin
                        addr_d = addr_q + AW'(1);
                    end
                    if (last_issue) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (fifo_empty && !infl_q) begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    busy = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        out_mem_t6_0_rd_en   = 1'b0;
        out_mem_t6_1_rd_en   = 1'b0;
        out_mem_t7_0_rd_en   = 1'b0;
        out_mem_t7_1_rd_en   = 1'b0;
        out_mem_t6_0_rd_addr = '0;
        out_mem_t6_1_rd_addr = '0;
        out_mem_t7_0_rd_addr = '0;
        out_mem_t7_1_rd_addr = '0;
        if (issue) begin
            unique case (sel_q)
                SEL_T6_0: begin out_mem_t6_0_rd_en = 1'b1; out_mem_t6_0_rd_addr = addr_q; end
                SEL_T6_1: begin out_mem_t6_1_rd_en = 1'b1; out_mem_t6_1_rd_addr = addr_q; end
                SEL_T7_0: begin out_mem_t7_0_rd_en = 1'b1; out_mem_t7_0_rd_addr = addr_q; end
                default:  begin out_mem_t7_1_rd_en = 1'b1; out_mem_t7_1_rd_addr = addr_q; end
            endcase
        end
    end

    always_comb begin
        unique case (infl_sel_q)
            SEL_T6_0: cap_data = mem_t6_0_dout;
            SEL_T6_1: cap_data = mem_t6_1_dout;
            SEL_T7_0: cap_data = mem_t7_0_dout;
            default:  cap_data = mem_t7_1_dout;
        endcase
    end

    assign fifo_din = {infl_last_q, infl_sel_q, cap_data};

    stream_skid2 #(
        .W(FW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (infl_q),
        .din   (fifo_din),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign out_valid = ~fifo_empty;
    assign out_last  = out_valid & fifo_dout[FW-1];
    assign out_sel   = out_valid ? fifo_dout[FW-2 -: 2] : 2'd0;
    assign out_data  = out_valid ? fifo_dout[RADIX-1:0] : '0;

`ifdef XDBLE_RESULT_READER_CHECKSUM_EN
    logic [RADIX-1:0] checksum_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum_q <= '0;
        end else if ((state_q == ST_IDLE) && start) begin
            checksum_q <= '0;
        end else if (pop) begin
            checksum_q <= checksum_q ^ out_data;
        end
    end

    assign checksum = checksum_q;
`endif

endmodule

// File: tb/tb_xdble_result_reader.sv
// Directed bench for xdble_result_reader: memory models, scoreboard queue of
// expected {last, sel, data} words, handshake monitor and timing checks.
module tb_xdble_result_reader;
    import xdble_result_reader_pkg::*;

    localparam int RADIX = 32;
    localparam int WR    = 14;
    localparam int AW    = 4;
    localparam int NW    = 4 * WR;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             out_ready = 1'b0;
    logic             busy, done, out_valid, out_last;
    logic [1:0]       dbg_state, out_sel;
    logic [RADIX-1:0] out_data;
    logic             rd_en   [4];
    logic [AW-1:0]    rd_addr [4];
    logic [RADIX-1:0] dout    [4];
    logic [RADIX-1:0] mem     [4][WR];
`ifdef XDBLE_RESULT_READER_CHECKSUM_EN
    logic [RADIX-1:0] checksum;
`endif

    logic [RADIX+2:0] exp_q[$];
    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int start_cyc, first_valid_cyc, last_cyc, done_cyc;
    int words_seen, last_cnt, done_cnt, reads_cnt;
    logic             prev_hold;
    logic [RADIX+2:0] prev_word;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial for (int m = 0; m < 4; m++) dout[m] = '0;

    // Registered read, one-cycle latency.
    always @(posedge clk) begin
        for (int m = 0; m < 4; m++)
            if (rd_en[m]) dout[m] <= mem[m][int'(rd_addr[m])];
    end

    xdble_result_reader #(
        .RADIX(RADIX),
        .WIDTH_REAL(WR)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .start                (start),
        .busy                 (busy),
        .done                 (done),
        .dbg_state            (dbg_state),
        .out_mem_t6_0_rd_en   (rd_en[0]),
        .out_mem_t6_1_rd_en   (rd_en[1]),
        .out_mem_t7_0_rd_en   (rd_en[2]),
        .out_mem_t7_1_rd_en   (rd_en[3]),
        .out_mem_t6_0_rd_addr (rd_addr[0]),
        .out_mem_t6_1_rd_addr (rd_addr[1]),
        .out_mem_t7_0_rd_addr (rd_addr[2]),
        .out_mem_t7_1_rd_addr (rd_addr[3]),
        .mem_t6_0_dout        (dout[0]),
        .mem_t6_1_dout        (dout[1]),
        .mem_t7_0_dout        (dout[2]),
        .mem_t7_1_dout        (dout[3]),
        .out_valid            (out_valid),
        .out_ready            (out_ready),
        .out_data             (out_data),
        .out_sel              (out_sel),
        .out_last             (out_last)
`ifdef XDBLE_RESULT_READER_CHECKSUM_EN
        ,
        .checksum             (checksum)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill_pattern();
        for (int s = 0; s < 4; s++)
            for (int a = 0; a < WR; a++)
                mem[s][a] = RADIX'((s << AW) | a);
    endtask

    task automatic load_expect();
        logic [1:0] s2;
        for (int s = 0; s < 4; s++) begin
            s2 = 2'(s);
            for (int a = 0; a < WR; a++)
                exp_q.push_back({(s == 3 && a == WR - 1), s2, mem[s][a]});
        end
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check("hold_valid", out_valid, 1'b1);
                check("hold_stable", {out_last, out_sel, out_data}, prev_word);
            end
            if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_word", 1'b1, 1'b0);
                end else begin
                    check("word", {out_last, out_sel, out_data}, exp_q.pop_front());
                end
                words_seen++;
                if (out_last) begin
                    last_cnt++;
                    last_cyc = cyc;
                end
            end
            if ((rd_en[0] | rd_en[1] | rd_en[2] | rd_en[3]) == 1'b1) begin
                check("rd_en_onehot", 32'(rd_en[0]) + 32'(rd_en[1]) + 32'(rd_en[2]) + 32'(rd_en[3]), 1);
                reads_cnt++;
            end
            if (done) begin
                check("busy_at_done", busy, 1'b0);
                done_cnt++;
                done_cyc = cyc;
            end
            prev_hold = out_valid && !out_ready;
            prev_word = {out_last, out_sel, out_data};
        end
    end

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_valid"}, out_valid, 1'b0);
        check({tag, "_stream"}, {out_last, out_sel, out_data}, '0);
        check({tag, "_rd"}, {rd_en[0], rd_en[1], rd_en[2], rd_en[3],
                             rd_addr[0], rd_addr[1], rd_addr[2], rd_addr[3]}, '0);
        check({tag, "_state"}, dbg_state, ST_IDLE);
    endtask

    // mode 0: ready high; 1: ready toggles; 2: ready low 10 cycles after first valid;
    // 3: second start pulse while busy.
    task automatic do_run(input int mode);
        int budget, d0, reads_base, reads_rel;
        logic released;
        d0 = done_cnt;
        first_valid_cyc = -1;
        words_seen = 0;
        last_cnt = 0;
        released = 1'b0;
        reads_rel = 0;
        load_expect();
        @(posedge clk); #1;
        start = 1'b1;
        start_cyc = cyc;
        reads_base = reads_cnt;
        out_ready = (mode == 2) ? 1'b0 : 1'b1;
        check("busy_cycle0", busy, 1'b0);
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_cycle1", busy, 1'b1);
        budget = 0;
        while (done_cnt == d0 && budget < 1000) begin
            if (mode == 1) out_ready = ~out_ready;
            if (mode == 2 && !released && first_valid_cyc >= 0 && cyc - first_valid_cyc >= 10) begin
                released  = 1'b1;
                reads_rel = reads_cnt - reads_base;
                out_ready = 1'b1;
            end
            @(posedge clk); #1;
            start = (mode == 3) && (budget == 5);
            budget++;
        end
        start = 1'b0;
        check("done_seen", done_cnt - d0, 1);
        repeat (10) @(posedge clk);
        #1;
        check("done_once", done_cnt - d0, 1);
        check("word_count", words_seen, NW);
        check("last_count", last_cnt, 1);
        check("queue_empty", exp_q.size(), 0);
        check("done_after_last", done_cyc - last_cyc, 1);
        if (mode == 0) begin
            check("first_valid_cycle", first_valid_cyc - start_cyc, 3);
            check("last_word_cycle", last_cyc - start_cyc, 4 * WR + 2);
            check("done_cycle", done_cyc - start_cyc, 4 * WR + 3);
        end
        if (mode == 2) begin
            check("hold_released", released, 1'b1);
            check("hold_reads_le2", (reads_rel <= 2), 1'b1);
        end
    endtask

    initial begin
        int budget;
        prev_hold = 1'b0;
        done_cnt = 0;
        reads_cnt = 0;
        first_valid_cyc = -1;
        fill_pattern();
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("in_reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_idle_outputs("after_reset");

        do_run(0);
        do_run(1);
        do_run(2);
        do_run(3);

        // Reset in the middle of a readout.
        first_valid_cyc = -1;
        words_seen = 0;
        load_expect();
        @(posedge clk); #1;
        start = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        budget = 0;
        while (words_seen < 20 && budget < 500) begin
            @(posedge clk); #1;
            budget++;
        end
        check("reached_word20", words_seen, 20);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("mid_reset");
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        check("reset_no_done", done, 1'b0);
        rst_n = 1'b1;
        do_run(0);

`ifdef XDBLE_RESULT_READER_CHECKSUM_EN
        for (int s = 0; s < 4; s++)
            for (int a = 0; a < WR; a++)
                mem[s][a] = 32'hFFFF_FFFF;
        mem[2][7] = 32'h0000_0001;
        do_run(0);
        check("checksum", checksum, 32'hFFFF_FFFE);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
